// File: rtl/rca_pipe_if.sv
// rtl/rca_pipe_if.sv - operand/result bundle for the pipelined ripple-carry adder
interface rca_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             stall;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, stall, a, b, cin, sub,
        input  out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, stall, a, b, cin, sub,
        output out_valid, s, cout, ovf
    );
endinterface

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor, one C-bit slice per stage
// Optional signed saturation of s on overflow when RCA_PIPE_SAT_EN is defined.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    rca_pipe_if.slave bus
);
    localparam int C = WIDTH / STAGES;

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             ovf_q;

    logic             v_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];

    logic             c_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [C:0]       slice [STAGES];
    logic             msb_cin;
    logic             ovf_d;

    // Stage 0 sees the raw bus with B and carry pre-inverted for subtract;
    // later stages see the previous stage's registers.
    always_comb begin
        v_in[0] = bus.in_valid;
        c_in[0] = bus.cin ^ bus.sub;
        a_in[0] = bus.a;
        b_in[0] = bus.sub ? ~bus.b : bus.b;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            c_in[k] = c_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    always_comb begin
        msb_cin = 1'b0;
        ovf_d   = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_in[k][k*C +: C]} + {1'b0, b_in[k][k*C +: C]}
                     + {{C{1'b0}}, c_in[k]};
            c_d[k]            = slice[k][C];
            s_d[k]            = s_in[k];
            s_d[k][k*C +: C]  = slice[k][C-1:0];
        end
        // The MSB sum bit is a^b^carry_in, so the carry into the MSB can be recovered from it.
        msb_cin = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1];
        ovf_d   = msb_cin ^ c_d[STAGES-1];
`ifdef RCA_PIPE_SAT_EN
        if (ovf_d) begin
            s_d[STAGES-1] = a_in[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!bus.stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.s         = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - scoreboard bench for rca_pipe (WIDTH=16, STAGES=4)
module tb_rca_pipe;
    localparam int W  = 16;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n_pop  = 0;
    logic last_adv = 1'b0;
    logic [W+1:0] q[$];

    rca_pipe_if #(.WIDTH(W)) bus ();
    rca_pipe #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: {cout, ovf, s} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                           input logic tc, input logic ts);
        longint ua, ub, full;
        int     sa, sb, sres;
        logic   co, ov;
        logic [W-1:0] sv;
        ua = longint'(ta);
        ub = longint'(tb_);
        sa = $signed(ta);
        sb = $signed(tb_);
        if (!ts) begin
            full = ua + ub + longint'(tc);
            co   = (full >= 65536);
            sres = sa + sb + int'(tc);
        end else begin
            full = ua - ub - longint'(tc);
            co   = (full >= 0);
            sres = sa - sb - int'(tc);
        end
        sv = full[W-1:0];
        ov = (sres > 32767) || (sres < -32768);
`ifdef RCA_PIPE_SAT_EN
        if (ov) sv = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {co, ov, sv};
    endfunction

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && !bus.stall)
            q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        last_adv = rst_n && !bus.stall;
    end

    always @(negedge clk) begin
        if (last_adv && bus.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got s=%h cout=%b ovf=%b, required no result", bus.s, bus.cout, bus.ovf);
            end else begin
                logic [W+1:0] exp;
                exp = q.pop_front();
                n_pop++;
                if ({bus.cout, bus.ovf, bus.s} !== exp) begin
                    errors++;
                    $display("FAIL result_value: got cout=%b ovf=%b s=%h, required cout=%b ovf=%b s=%h",
                             bus.cout, bus.ovf, bus.s, exp[W+1], exp[W], exp[W-1:0]);
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        bus.stall = 1'b0; bus.in_valid = 1'b1;
        bus.a = ta; bus.b = tb_; bus.cin = tc; bus.sub = ts;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 4 * ST && q.size() != 0; t++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, q.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus.out_valid, bus.cout, bus.ovf, bus.s} !== '0) begin
            errors++;
            $display("FAIL %s: got out_valid=%b cout=%b ovf=%b s=%h, required all 0",
                     name, bus.out_valid, bus.cout, bus.ovf, bus.s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.stall = 1'b0; bus.in_valid = 1'b1;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'b1; bus.sub = 1'b0;
        #2 check_zero("reset_before_edge");
        repeat (3) begin
            @(posedge clk); #1 check_zero("reset_after_posedge");
            bus.a = W'($urandom); bus.b = W'($urandom);
            @(negedge clk); check_zero("reset_at_negedge");
        end
        rst_n = 1'b1; bus.in_valid = 1'b0;
    endtask

    // Latency and single-cycle out_valid, first op issued right after reset release.
    task automatic test_full_ripple();
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < ST + 2; i++) begin
            checks++;
            if (bus.out_valid !== (i == ST - 1)) begin
                errors++;
                $display("FAIL ripple_valid_c%0d: got out_valid=%b, required %b", i, bus.out_valid, (i == ST - 1));
            end
            if (i == ST - 1) begin
                checks++;
                if ({bus.cout, bus.ovf, bus.s} !== {1'b1, 1'b0, 16'h0000}) begin
                    errors++;
                    $display("FAIL ripple_value: got cout=%b ovf=%b s=%h, required cout=1 ovf=0 s=0000",
                             bus.cout, bus.ovf, bus.s);
                end
            end
            @(negedge clk);
        end
        drain("ripple");
    endtask

    task automatic test_overflow();
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        drive(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        drain("overflow");
    endtask

    task automatic test_subtract();
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        drive(16'h0005, 16'h0003, 1'b1, 1'b1);
        drive(16'h0000, 16'h0000, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        drain("subtract");
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] snap;
        logic [W-1:0] pool [5];
        int pop0;
        pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h7FFF; pool[3] = 16'h8000; pool[4] = 16'h0001;
        pop0 = n_pop;
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
            if (i == 40) begin
                snap = {bus.out_valid, bus.cout, bus.ovf, bus.s};
                bus.stall = 1'b1; bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({bus.out_valid, bus.cout, bus.ovf, bus.s} !== snap) begin
                        errors++;
                        $display("FAIL stall_hold: got %h, required %h",
                                 {bus.out_valid, bus.cout, bus.ovf, bus.s}, snap);
                    end
                end
            end
            drive(ra, rb, 1'(($urandom)), 1'(($urandom)));
        end
        bus.in_valid = 1'b0;
        drain("stream");
        checks++;
        if (n_pop - pop0 != 80) begin
            errors++;
            $display("FAIL stream_count: got %0d results, required 80", n_pop - pop0);
        end
    endtask

    task automatic test_reset_mid();
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        drive(16'h4321, 16'h0101, 1'b1, 1'b0);
        drive(16'h0F0F, 16'h00F0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_preload: got out_valid=%b, required 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("midreset_async");
        q.delete();
        bus.in_valid = 1'b1; bus.stall = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midreset_held");
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.stall = 1'b0;
        for (int i = 0; i < ST + 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale_c%0d: got out_valid=%b, required 0", i, bus.out_valid);
            end
        end
        drive(16'h0002, 16'h0003, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < ST; i++) begin
            checks++;
            if (bus.out_valid !== (i == ST - 1)) begin
                errors++;
                $display("FAIL midreset_latency_c%0d: got out_valid=%b, required %b", i, bus.out_valid, (i == ST - 1));
            end
            @(negedge clk);
        end
        drain("midreset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_ripple();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add into STAGES equal carry-chained slices, one slice per clock.
- Accepts one operation per cycle, with valid tagging, a global stall and a signed-overflow flag.
- Serves as the arithmetic datapath primitive for wider accumulators and ALU blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of STAGES.
- STAGES, 4, number of pipeline slices and latency in cycles; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b/cin/sub are valid this cycle.
- stall  input  1  freeze the whole pipeline this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  s/cout/ovf hold a completed result.
- s  output  WIDTH  sum or difference.
- cout  output  1  carry-out (add); not-borrow (subtract).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n = 0, asynchronous, independent of clk):
  - every pipeline register and valid bit clears immediately;
  - out_valid = 0, s = 0, cout = 0, ovf = 0;
  - on release, the first operation is accepted on the first rising edge with rst_n = 1.
- Arithmetic:
  - sub = 0: {cout, s} = a + b + cin.
  - sub = 1: {cout, s} = a + ~b + ~cin, i.e. s = a - b - cin mod 2^WIDTH; cout = 1 means no borrow.
  - ovf = carry into the MSB XOR carry out of the MSB.
- Slicing and alignment:
  - slice width C = WIDTH/STAGES.
  - Stage k (k = 0..STAGES-1) adds bits [k*C +: C] of A and of the B operand (inverted when sub = 1), using the carry registered by stage k-1; stage 0 uses cin (inverted when sub = 1).
  - Upper operand bits are skewed forward through registers; completed lower sum bits are delayed.
  - All bits of one operation, plus cout and ovf, appear on the outputs in the same cycle.
- Latency and throughput:
  - a result is presented exactly STAGES non-stalled cycles after its operation is accepted;
  - one operation per cycle sustained; results leave in issue order.
- Valid:
  - a valid bit travels with each slot; out_valid is the valid bit of the final stage;
  - s, cout and ovf are don't-care when out_valid = 0, but must not be X after reset.
- Stall:
  - stall = 1 at a rising edge: every register, including the outputs, holds its value, and in_valid/a/b/cin/sub are not accepted;
  - the source must re-present the operation once stall is low;
  - stall has no effect on reset.
- Simultaneous events: rst_n low overrides stall and in_valid.
- Reset mid-operation: in-flight operations are discarded; no stale result may appear after reset is released.
- STAGES = 1: the block degenerates to a single registered WIDTH-bit adder with latency 1.

Optional Feature:
- Macro RCA_PIPE_SAT_EN.
- When defined: on ovf = 1, s saturates to the signed limit:
  - 0x7F..F when the true result is positive;
  - 0x80..0 when it is negative (sign taken from A's MSB carried through the pipeline);
  - ovf still reports the overflow; cout is unchanged.
- When undefined: s wraps modulo 2^WIDTH, and no sign-tracking register exists.

Test Plan:
- Reset: rst_n = 0 with in_valid = 1 and random operands -> out_valid = 0, s = 0x0000, cout = 0, ovf = 0, including between clock edges.
- Full carry ripple (WIDTH = 16, STAGES = 4): a = 0xFFFF, b = 0x0001, cin = 0, sub = 0 -> 4 cycles later s = 0x0000, cout = 1, ovf = 0, out_valid = 1 for exactly one cycle.
- Signed overflow: a = 0x7FFF, b = 0x0001, add -> s = 0x8000, ovf = 1, cout = 0; with RCA_PIPE_SAT_EN, s = 0x7FFF.
- Subtract with borrow: a = 0x0005, b = 0x0007, cin = 0, sub = 1 -> s = 0xFFFE, cout = 0, ovf = 0; and a = 0x0005, b = 0x0003, cin = 1, sub = 1 -> s = 0x0001, cout = 1.
- Streaming: 80 back-to-back random operations, with stall = 1 for 3 cycles mid-stream -> every result matches the reference model, is in order, with no loss or duplication, and outputs are held during the stall.
- Reset mid-stream: rst_n pulsed low with 3 operations in flight -> out_valid falls at once; after release no out_valid appears until a new accepted operation has had STAGES cycles.
